// File: rtl/mips_alu_seq.sv
// Sequential MIPS-style ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply (shift-add) and unsigned divide (restoring), one bit per cycle.
module mips_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             vld_p0;
  logic [3:0]       ctrl_p0;
  logic [WIDTH-1:0] srca_p0;
  logic [WIDTH-1:0] srcb_p0;

  logic [WIDTH-1:0] hi_w;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  logic accept;
  logic is_multi;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] as;
    logic signed [WIDTH-1:0] bs;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    as = a;
    bs = b;
    sh = a[SHW-1:0];
    r  = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (as < bs)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = bs >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic ovf_fn(input logic [3:0]       op,
                                  input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             o;
    o = 1'b0;
    if (op == OP_ADD) begin
      r = a + b;
      o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else if (op == OP_SUB) begin
      r = a - b;
      o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return o;
  endfunction

  assign accept   = Start && !Busy;
  assign is_multi = (ALUControl == OP_MULU) || (ALUControl == OP_DIVU);
  assign Zero     = (ALUResult == '0);

  // One iteration of either engine. For a zero divisor the restoring step
  // never borrows, which naturally yields quotient all-ones and remainder = dividend.
  always_comb begin
    mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, srcb_p0} : '0);
    div_shift = {hi_w, lo_w[WIDTH-1]};
    div_diff  = div_shift - {1'b0, srcb_p0};
    hi_nxt    = '0;
    lo_nxt    = '0;
    if (ctrl_p0 == OP_MULU) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_w[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      hi_nxt = div_diff[WIDTH-1:0];
      lo_nxt = {lo_w[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = div_shift[WIDTH-1:0];
      lo_nxt = {lo_w[WIDTH-2:0], 1'b0};
    end
  end

  // Stage p0: operand capture on acceptance; iteration working registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      srca_p0 <= SrcA;
      srcb_p0 <= SrcB;
      ctrl_p0 <= ALUControl;
      hi_w    <= '0;
      lo_w    <= SrcA;
    end else if (state == ITER) begin
      hi_w <= hi_nxt;
      lo_w <= lo_nxt;
    end
  end

  // Stage p1: result registers, handshake and sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      vld_p0    <= 1'b0;
      ALUResult <= '0;
      Hi        <= '0;
      Overflow  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          vld_p0 <= 1'b0;
          if (vld_p0) begin
            ALUResult <= alu_fn(ctrl_p0, srca_p0, srcb_p0);
            Overflow  <= ovf_fn(ctrl_p0, srca_p0, srcb_p0);
            Done      <= 1'b1;
          end
          if (accept) begin
            if (is_multi) begin
              state <= ITER;
              Busy  <= 1'b1;
              cnt   <= '0;
            end else begin
              vld_p0 <= 1'b1;
            end
          end
        end
        ITER: begin
          if (cnt == LAST_ITER) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            cnt       <= '0;
            ALUResult <= lo_nxt;
            Hi        <= hi_nxt;
            Overflow  <= 1'b0;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed and randomised checks of mips_alu_seq with an expected-result queue.
module tb_mips_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [3:0]   ALUControl = 4'b0000;
  logic         Start = 1'b0;
  logic [W-1:0] ALUResult;
  logic [W-1:0] Hi;
  logic         Zero;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  mips_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .Start(Start), .ALUResult(ALUResult),
    .Hi(Hi), .Zero(Zero), .Overflow(Overflow), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] model_hi = '0;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] hprev);
    exp_t            e;
    logic [63:0]     p;
    logic signed [W:0] s;
    int              sh;
    e.res = '0;
    e.hi  = hprev;
    e.ovf = 1'b0;
    sh    = int'(a[4:0]);
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.res = s[W-1:0];
        e.ovf = s[W] ^ s[W-1];
      end
      4'b0110: begin
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.res = s[W-1:0];
        e.ovf = s[W] ^ s[W-1];
      end
      4'b0111: e.res[0] = ($signed(a) < $signed(b));
      4'b1111: e.res[0] = (a < b);
      4'b0011: e.res = a ^ b;
      4'b0100: e.res = ~(a | b);
      4'b1000: e.res = b << sh;
      4'b1001: e.res = b >> sh;
      4'b1010: e.res = $unsigned($signed(b) >>> sh);
      4'b1100: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      4'b1101: begin
        if (b == '0) begin
          e.res = '1;
          e.hi  = a;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b, model_hi);
    model_hi = e.hi;
    sbq.push_back(e);
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Waits for Done (bounded), checks latency/Busy cycles if exp_lat>0, and pops the scoreboard.
  task automatic collect(input string tag, input int exp_lat, input int exp_busy);
    int   n;
    int   nb;
    bit   got;
    exp_t e;
    n = 0;
    nb = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (Done === 1'b1) got = 1'b1;
      else if (Busy === 1'b1) nb++;
    end
    chk({tag, "_done"}, 64'(Done), 64'(1));
    if (got) begin
      if (exp_lat > 0) begin
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busycyc"}, 64'(nb), 64'(exp_busy));
      end
      if (sbq.size() == 0) begin
        chk({tag, "_sbq"}, 64'(sbq.size()), 64'(1));
      end else begin
        e = sbq.pop_front();
        chk({tag, "_res"}, 64'(ALUResult), 64'(e.res));
        chk({tag, "_hi"}, 64'(Hi), 64'(e.hi));
        chk({tag, "_ovf"}, 64'(Overflow), 64'(e.ovf));
        chk({tag, "_zero"}, 64'(Zero), 64'(e.res == '0));
      end
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    bit multi;
    multi = (op == 4'b1100) || (op == 4'b1101);
    issue(op, a, b);
    collect(tag, multi ? 33 : 2, multi ? 32 : 0);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, 64'(Done), 64'(0));
  endtask

  initial begin
    logic [3:0] codes[16];
    int         nd;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111, 4'b0011, 4'b0100,
              4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1011, 4'b1110};

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(ALUResult), 64'(0));
    chk("rst_hi", 64'(Hi), 64'(0));
    chk("rst_zero", 64'(Zero), 64'(1));
    chk("rst_ovf", 64'(Overflow), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single-cycle operations
    run("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    idle_chk("add_pulse");
    run("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    run("sltu", 4'b1111, 32'hFFFF_FFFF, 32'h0000_0001);
    run("sra", 4'b1010, 32'h0000_0004, 32'h8000_0000);
    run("sll", 4'b1000, 32'h0000_0023, 32'h0000_00F1);
    run("srl", 4'b1001, 32'h0000_001F, 32'h8000_0000);
    run("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001);
    run("sub_zero", 4'b0110, 32'h1234_5678, 32'h1234_5678);
    run("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run("or", 4'b0001, 32'hF000_0001, 32'h000F_0010);
    run("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000);
    run("nor", 4'b0100, 32'h0F0F_0000, 32'h0000_F0F0);
    run("undef", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_chk("undef_pulse");

    // Multi-cycle operations
    run("mul_max", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_chk("mul_pulse");
    run("div_100_7", 4'b1101, 32'd100, 32'd7);
    run("div_by0", 4'b1101, 32'd5, 32'd0);
    run("add_keephi", 4'b0010, 32'd10, 32'd20);

    // Back-to-back: AND issued in the DIVU Done cycle
    run("b2b_div", 4'b1101, 32'd100, 32'd7);
    run("b2b_and", 4'b0000, 32'hFFFF_00FF, 32'h1234_5678);
    idle_chk("b2b_pulse");

    // Start during MULTU must be ignored
    issue(4'b1100, 32'h0001_2345, 32'h0000_6789);
    repeat (4) @(posedge clk);
    #1;
    ALUControl = 4'b0110;
    SrcA = 32'd9;
    SrcB = 32'd4;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    collect("mul_ign", -1, 0);
    idle_chk("mul_ign_nd1");
    idle_chk("mul_ign_nd2");
    idle_chk("mul_ign_nd3");

    // Reset at iteration 10 of a MULTU
    ALUControl = 4'b1100;
    SrcA = 32'h0000_DEAD;
    SrcB = 32'h0000_BEEF;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    model_hi = '0;
    chk("rmid_res", 64'(ALUResult), 64'(0));
    chk("rmid_hi", 64'(Hi), 64'(0));
    chk("rmid_zero", 64'(Zero), 64'(1));
    chk("rmid_ovf", 64'(Overflow), 64'(0));
    chk("rmid_busy", 64'(Busy), 64'(0));
    chk("rmid_done", 64'(Done), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) nd++;
    end
    chk("rmid_nodone", 64'(nd), 64'(0));
    run("rmid_add", 4'b0010, 32'd2, 32'd3);

    // Random mix over every code, including undefined ones
    for (int i = 0; i < 16; i++) begin
      run("rand", codes[$urandom_range(0, 15)], $urandom, $urandom);
    end
    idle_chk("rand_pulse");
    chk("sbq_empty", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_seq.md
MIPS_ALU_SEQ -- requirements
Module: mips_alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand/result width; legal values are powers of two, 8..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port SrcA, input, WIDTH, the first operand.
REQ-005 The block SHALL have port SrcB, input, WIDTH, the second operand.
REQ-006 The block SHALL have port ALUControl, input, 4, the operation select, sampled with Start.
REQ-007 The block SHALL have port Start, input, 1, the request strobe.
REQ-008 The block SHALL have port ALUResult, output, WIDTH, the result, or the low product/quotient.
REQ-009 The block SHALL have port Hi, output, WIDTH, the high product or remainder.
REQ-010 The block SHALL have port Zero, output, 1, asserted when ALUResult equals 0.
REQ-011 The block SHALL have port Overflow, output, 1, the signed overflow of ADD/SUB.
REQ-012 The block SHALL have port Busy, output, 1, indicating a multi-cycle operation is in progress.
REQ-013 The block SHALL have port Done, output, 1, a one-cycle pulse indicating results are valid.

Function
REQ-014 The block SHALL decode ALUControl as follows: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1111 SLTU; 0011 XOR; 0100 NOR; 1000 SLL; 1001 SRL; 1010 SRA; 1100 MULTU; 1101 DIVU; any other code gives a result of 0.
REQ-015 The block SHALL accept Start only when Busy=0 and SHALL latch SrcA, SrcB and ALUControl on the accepting edge; Start while Busy=1 SHALL be ignored with no effect on state.
REQ-016 For shifts, the block SHALL shift SrcB by SrcA[log2(WIDTH)-1:0]; SRA SHALL replicate SrcB's MSB.
REQ-017 For SLT and SLTU, ALUResult SHALL be 1 when true and 0 otherwise, zero-extended to WIDTH.
REQ-018 Single-cycle ops SHALL update ALUResult on the edge after acceptance (edge E1), SHALL leave Hi unchanged, and SHALL pulse Done for exactly the cycle following E1; Busy SHALL stay 0.
REQ-019 MULTU SHALL be an unsigned shift-add over WIDTH iterations, with Busy=1 from the accepting edge E0 until edge E_WIDTH.
REQ-020 At edge E_WIDTH of MULTU, the block SHALL deassert Busy, pulse Done for one cycle, and load {Hi,ALUResult} with the 2*WIDTH-bit product.
REQ-021 DIVU SHALL be unsigned restoring division with the same timing as MULTU, producing ALUResult=quotient and Hi=remainder.
REQ-022 For DIVU with divisor 0, the block SHALL produce quotient all-ones and remainder SrcA, with no other flag.
REQ-023 The state machine SHALL have states IDLE and ITER: IDLE -> ITER on an accepted MULTU/DIVU; ITER -> IDLE when the iteration counter reaches WIDTH-1; single-cycle ops stay in IDLE.
REQ-024 Overflow SHALL be registered with ALUResult and SHALL equal the signed overflow for ADD/SUB, otherwise 0.
REQ-025 Zero SHALL be derived combinationally from the registered ALUResult.
REQ-026 ALUResult, Hi, Zero and Overflow SHALL hold their values until the next completion.
REQ-027 Start accepted in the same cycle that Done is high SHALL be legal, giving back-to-back operation with no bubble.

Reset
REQ-028 Assertion of reset_n=0 SHALL immediately force state=IDLE, counter=0, ALUResult=0, Hi=0, Overflow=0, Busy=0 and Done=0; Zero SHALL therefore be 1.
REQ-029 Reset during ITER SHALL abort the operation with no Done pulse; the first Start after deassertion SHALL be accepted normally.

Verification
REQ-030 With WIDTH=32, ADD of SrcA=0x7FFFFFFF and SrcB=1 -> one cycle later ALUResult=0x80000000, Overflow=1, Zero=0, one Done pulse.
REQ-031 SLT with 0xFFFFFFFF and 1 -> ALUResult=1; SLTU with the same operands -> ALUResult=0; SRA of 0x80000000 by 4 -> 0xF8000000.
REQ-032 MULTU of 0xFFFFFFFF and 0xFFFFFFFF -> Busy for 32 cycles, then Hi=0xFFFFFFFE, ALUResult=0x00000001, one Done pulse.
REQ-033 DIVU of 100 and 7 -> quotient 14, remainder 2; DIVU of 5 and 0 -> ALUResult=0xFFFFFFFF, Hi=5.
REQ-034 Start with SUB issued mid-MULTU is ignored; reset_n pulsed low at iteration 10 gives all outputs 0 and no Done, and a subsequent ADD 2+3 gives 5.
REQ-035 Back-to-back Start in the Done cycle (DIVU then AND) -> the AND result appears one cycle after acceptance while Hi keeps the DIVU remainder.
